// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, issues one imem read per cycle under a credit
// limit, and buffers returned instructions with their next-PC for decode.
module fetch_queue #(
  parameter int          AW       = 16,
  parameter int          IW       = 16,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_INC   = 1,
  localparam int         CW       = $clog2(DEPTH + 1),
  localparam int         PW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_next_pc,
  output logic [CW-1:0] count
);

  logic [AW-1:0] r_fpc;
  logic          r_inflight;
  logic [AW-1:0] r_tag;
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_instr [DEPTH];
  logic [AW-1:0] r_npc   [DEPTH];

  logic          w_run, w_credit, w_push, w_pop;
  logic [AW-1:0] w_fpc_inc;

  always_comb begin
    w_run     = !rst && !halt && !redirect;
    // In-flight response already owns a slot, so it counts against credit.
    w_credit  = ({1'b0, r_count} + (CW+1)'(r_inflight)) < (CW+1)'(DEPTH);
    w_fpc_inc = r_fpc + AW'(PC_INC);
    imem_req  = w_run && w_credit;
    out_valid = w_run && (r_count != '0);
    w_push    = w_run && r_inflight;
    w_pop     = out_valid && out_ready;
  end

  assign imem_addr   = r_fpc;
  assign out_instr   = r_instr[r_rp];
  assign out_next_pc = r_npc[r_rp];
  assign count       = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc      <= AW'(RESET_PC);
      r_inflight <= 1'b0;
      r_tag      <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
    end else if (halt || redirect) begin
      r_fpc      <= halt ? AW'(RESET_PC) : redirect_pc;
      r_inflight <= 1'b0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
    end else begin
      if (imem_req) r_fpc <= w_fpc_inc;
      r_inflight <= imem_req;
      r_tag      <= w_fpc_inc;
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wp] <= imem_data;
      r_npc[r_wp]   <= r_tag;
    end
  end

endmodule
